and_unit_arbiter: RTL
=====================

# and_unit_arbiter

Round-robin arbiter and sequencer that shares one registered 8-bit bitwise-AND unit (`c = a & b`, one clock of latency) among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, launches that pair into the AND unit, and returns the result tagged with the requester index over a response handshake that supports backpressure. It sits between the operand-generating clients and the shared AND datapath, and it is the only driver of that datapath.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 8: operand and result width.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response tag. Derived; never overridden.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has an operand pair pending.
- `req_ready`  out  NUM_REQ  one-hot or zero; requester i is accepted this cycle.
- `req_a`  in  NUM_REQ*WIDTH  operand a; requester i occupies slice [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  operand b; same packing as `req_a`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_c`  out  WIDTH  result, `a & b`.
- `rsp_id`  out  ID_W  index of the requester that produced `rsp_c`.

## Operation
- Pipeline has two stages:
  - S1 (issue): holds the operand pair and id registered into the AND unit.
  - S2 (result): holds the AND unit's registered `c` plus id.
- Each stage has a valid bit. Occupancy states are EMPTY, S1 only, S2 only, and FULL (S1 and S2).
- Advance rules:
  - `adv2 = !s2_v | rsp_ready`.
  - `adv1 = !s1_v | adv2`.
  - A stage holds its contents when it cannot advance.
- Grant:
  - When `adv1` is high, `req_ready` has exactly one bit set: the first i with `req_valid[i]`, searching from pointer `ptr` upward with wrap from `NUM_REQ-1` to 0.
  - When `adv1` is low, or no requester is valid, `req_ready` is all zero.
  - `req_ready[i]` may only be high when `req_valid[i]` is high.
- Accept: on `req_valid[i] & req_ready[i]`, S1 captures `req_a[i]`, `req_b[i]`, and i. At the same edge, `ptr` becomes `(i+1) mod NUM_REQ`.
- If no accept occurs, `ptr` holds its value.
- S2 loads `s1_a & s1_b` and the id when `adv2` and `s1_v` are both high.
- `rsp_valid = s2_v`. `rsp_c` and `rsp_id` are driven directly from S2 registers.
- Arithmetic is a bitwise AND only. There is no carry or overflow.
- Requesters must hold valid and operands stable until accepted. The block does not check this.

## Timing
- Reset values: `s1_v = 0`, `s2_v = 0`, `ptr = 0`, `rsp_valid = 0`, `rsp_c = 0`, `rsp_id = 0`. `req_ready` is all zero during the reset cycle.
- Latency: accept at edge k gives `rsp_valid` high after edge k+1, with no backpressure.
- Throughput: one result per cycle while `rsp_ready` is held high.
- Backpressure:
  - With `rsp_valid` high and `rsp_ready` low, S2 holds.
  - S1 still accepts one more pair if it is empty.
  - When both stages are full, `req_ready` is 0.
- Same-cycle accept and retire:
  - A FULL pipeline with `rsp_ready` high shifts S1 to S2 and accepts a new pair into S1 on the same edge.
  - There is no bubble.
- Reset mid-operation: both in-flight results are discarded with no response. `ptr` returns to 0.
- `req_valid` dropping without an accept is legal. It is ignored.
- Pointer wrap: after granting requester `NUM_REQ-1`, `ptr` becomes 0.

## Configuration
- Macro: `AND_UNIT_ARBITER_FIXED_PRIO_EN`.
- Defined: fixed priority. The lowest valid index always wins, and `ptr` is not implemented.
- Undefined (default): round-robin as described under Operation.
- Handshake, latency and reset behaviour are identical in both builds.

## Structure
- Package `and_unit_arb_pkg` contains:
  - the `DEF_WIDTH = 8` and `DEF_NUM_REQ = 4` constants;
  - the occupancy enum (EMPTY, S1, S2, FULL), used for debug/assertions;
  - the function `rr_pick(valid, ptr)`, which returns the grant index and a found flag.
- One sub-module, `and_unit`: a registered `c <= a & b` with a load enable. It is instantiated once, as S2.
- The arbiter's top level holds S1, the grant logic, `ptr` and the handshake logic.

## Test plan
- Single request:
  - Stimulus: `rst` high for 2 cycles; then `req_valid = 0001`, `a0 = 8'hF0`, `b0 = 8'h3C`, `rsp_ready = 1`.
  - Required response: `req_ready = 0001` for one cycle, then `rsp_valid` 2 cycles after the accept, with `rsp_c = 8'h30` and `rsp_id = 0`.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously valid, `rsp_ready = 1`.
  - Required response: grant order is 0, 1, 2, 3, 0, 1 with one response per cycle; `rsp_id` follows the same order.
- Backpressure:
  - Stimulus: `rsp_ready = 0` with 3 requesters valid.
  - Required response: exactly 2 accepts, then `req_ready = 0000` with `rsp_c` stable. After `rsp_ready` goes to 1, responses drain in grant order.
- Pointer wrap with sparse requests:
  - Stimulus: `ptr = 3` (after grant 2), `req_valid = 0011`.
  - Required response: grant 0, then 1.
- Reset mid-flight:
  - Stimulus: assert `rst` while the pipeline is FULL.
  - Required response: the next cycle shows `rsp_valid = 0`; the next grant goes to requester 0.
- Fixed-priority build (`AND_UNIT_ARBITER_FIXED_PRIO_EN` defined):
  - Stimulus: `req_valid = 1111`.
  - Required response: requester 0 is granted on every cycle.

Source files
------------

// File: rtl/and_unit_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : and_unit_arb_pkg
// Description : Shared constants, occupancy encoding and the round-robin
//               pick function used by the AND-unit arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package and_unit_arb_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    // Upper bound on requesters; rr_pick works on vectors of this size so a
    // single function serves every NUM_REQ instance.
    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    // Pipeline occupancy, encoded as {s2_v, s1_v}.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_S1    = 2'b01,
        OCC_S2    = 2'b10,
        OCC_FULL  = 2'b11
    } occ_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First valid index at or above ptr, wrapping at num_req. Bits of valid
    // at or above num_req are ignored.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int                   num_req);
        pick_t r;
        int    idx;
        r = '0;
        for (int off = 0; off < MAX_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if ((off < num_req) && !r.found && valid[idx[MAX_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[MAX_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/and_unit_arbiter_and_unit.sv
`default_nettype none
// ============================================================================
// Module      : and_unit
// Description : Registered bitwise AND (c <= a & b) with load enable. The
//               tag travels alongside the result so the response carries the
//               originating requester index.
// Ports       : clk, rst      clock / synchronous active-high reset
//               load_i        capture a & b and tag this edge
//               a_i, b_i      operands
//               tag_i         requester index accompanying the operands
//               c_o, tag_o    registered result and tag
// Revision    : 1.0  initial release
// ============================================================================
module and_unit
    import and_unit_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic [WIDTH-1:0] c_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [WIDTH-1:0] c_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= '0;
            tag_q <= '0;
        end else if (load_i) begin
            c_q   <= a_i & b_i;
            tag_q <= tag_i;
        end
    end

    assign c_o   = c_q;
    assign tag_o = tag_q;

endmodule
`default_nettype wire

// File: rtl/and_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : and_unit_arbiter
// Description : Arbitrates NUM_REQ valid/ready requesters onto one shared
//               registered AND unit. Two-stage pipeline: S1 holds the issued
//               operand pair and id, S2 (the and_unit) holds the result and
//               id. Results return over rsp_* with backpressure.
// Config      : AND_UNIT_ARBITER_FIXED_PRIO_EN defined -> fixed priority
//               (lowest valid index wins, no pointer). Undefined (default)
//               -> round-robin starting from ptr.
// Ports       : clk, rst            clock / synchronous active-high reset
//               req_valid/req_ready per-requester handshake (ready one-hot)
//               req_a, req_b        packed operands, slice [i*WIDTH +: WIDTH]
//               rsp_valid/rsp_ready result handshake
//               rsp_c, rsp_id       result and originating requester index
// Revision    : 1.0  initial release
// ============================================================================
module and_unit_arbiter
    import and_unit_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_c,
    output logic [ID_W-1:0]          rsp_id
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             s1_v_q,  s1_v_d;
    logic [WIDTH-1:0] s1_a_q,  s1_a_d;
    logic [WIDTH-1:0] s1_b_q,  s1_b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic             s2_v_q,  s2_v_d;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_accept;
    logic             w_s2_load;
    pick_t            w_pick;
    logic [ID_W-1:0]  w_grant_id;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    occ_e             w_occ;

    // ------------------------------------------------------------------
    // Advance: S2 moves when empty or being consumed; S1 moves when empty
    // or when S2 can take its contents.
    // ------------------------------------------------------------------
    assign w_adv2    = !s2_v_q || rsp_ready;
    assign w_adv1    = !s1_v_q || w_adv2;
    assign w_s2_load = w_adv2 && s1_v_q;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
`ifdef AND_UNIT_ARBITER_FIXED_PRIO_EN
    always_comb begin
        w_pick = rr_pick(MAX_REQ'(req_valid), '0, NUM_REQ);
    end
`else
    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        w_pick = rr_pick(MAX_REQ'(req_valid), MAX_IDX_W'(ptr_q), NUM_REQ);
    end
`endif

    assign w_grant_id = ID_W'(w_pick.idx);

    // One-hot ready and operand mux. Ready is suppressed during reset so no
    // requester believes it was accepted by an edge that discards state.
    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(w_pick.idx) == i) begin
                req_ready[i] = w_pick.found && w_adv1 && !rst;
                w_sel_a      = req_a[i*WIDTH +: WIDTH];
                w_sel_b      = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_accept = |req_ready;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        s1_v_d  = s1_v_q;
        s1_a_d  = s1_a_q;
        s1_b_d  = s1_b_q;
        s1_id_d = s1_id_q;
        s2_v_d  = s2_v_q;

        // When S1 advances its old content has left (or it was empty), so
        // its valid simply reflects whether a new pair arrives.
        if (w_adv1) begin
            s1_v_d = w_accept;
            if (w_accept) begin
                s1_a_d  = w_sel_a;
                s1_b_d  = w_sel_b;
                s1_id_d = w_grant_id;
            end
        end

        if (w_adv2) begin
            s2_v_d = s1_v_q;
        end
    end

`ifndef AND_UNIT_ARBITER_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (w_accept) begin
            ptr_d = (int'(w_pick.idx) == NUM_REQ - 1) ? '0 : w_grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
        end else begin
            s1_v_q  <= s1_v_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s1_id_q <= s1_id_d;
            s2_v_q  <= s2_v_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: the shared AND unit
    // ------------------------------------------------------------------
    and_unit #(
        .WIDTH (WIDTH),
        .TAG_W (ID_W)
    ) u_s2 (
        .clk    (clk),
        .rst    (rst),
        .load_i (w_s2_load),
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .tag_i  (s1_id_q),
        .c_o    (rsp_c),
        .tag_o  (rsp_id)
    );

    assign rsp_valid = s2_v_q;

    // ------------------------------------------------------------------
    // Handshake invariants
    // ------------------------------------------------------------------
    assign w_occ = occ_e'({s2_v_q, s1_v_q});

    always @(posedge clk) begin
        if (!rst) begin
            assert ((req_ready & ~req_valid) == '0);
            assert (!((w_occ == OCC_FULL) && !rsp_ready && (req_ready != '0)));
        end
    end

endmodule
`default_nettype wire
